// File: rtl/vx_credit_arbiter_pkg.sv
// Shared widths and FSM encoding for the credit arbiter and its interface.
package vx_credit_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic int calc_idxw(input int num_reqs);
        return ($clog2(num_reqs) > 1) ? $clog2(num_reqs) : 1;
    endfunction

    function automatic int calc_sizew(input int size);
        return $clog2(size + 1);
    endfunction

    function automatic int calc_pcw(input int per_req_max);
        return $clog2(per_req_max + 1);
    endfunction

endpackage

// File: rtl/vx_credit_arbiter_if.sv
// Request/grant/return bundle between the requesters and the credit arbiter.
interface vx_credit_arbiter_if #(
    parameter int NUM_REQS = 4,
    parameter int SIZE     = 8
);
    import vx_credit_arbiter_pkg::*;

    localparam int IDXW  = calc_idxw(NUM_REQS);
    localparam int SIZEW = calc_sizew(SIZE);

    logic [NUM_REQS-1:0] req_valid;
    logic [NUM_REQS-1:0] req_ready;
    logic                grant_valid;
    logic [IDXW-1:0]     grant_index;
    logic                grant_ready;
    logic                rsp_valid;
    logic [IDXW-1:0]     rsp_index;
    logic                empty;
    logic                full;
    logic [SIZEW-1:0]    size;

    modport master (
        output req_valid, grant_ready, rsp_valid, rsp_index,
        input  req_ready, grant_valid, grant_index, empty, full, size
    );

    modport slave (
        input  req_valid, grant_ready, rsp_valid, rsp_index,
        output req_ready, grant_valid, grant_index, empty, full, size
    );

endinterface

// File: rtl/vx_rr_pick.sv
// Combinational round-robin picker: first eligible requester strictly after last_idx_i.
module vx_rr_pick #(
    parameter int NUM_REQS = 4,
    parameter int IDXW     = 2
) (
    input  logic [NUM_REQS-1:0] eligible_i,
    input  logic [IDXW-1:0]     last_idx_i,
    output logic [IDXW-1:0]     pick_idx_o,
    output logic                pick_valid_o
);

    logic [IDXW-1:0] cand;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        pick_valid_o = 1'b0;
        pick_idx_o   = '0;
        cand         = '0;
        // Offsets 1..NUM_REQS visit every requester once, ending on last_idx itself.
        for (int off = 1; off <= NUM_REQS; off++) begin
            cand = IDXW'((int'(last_idx_i) + off) % NUM_REQS);
            if (!pick_valid_o && eligible_i[cand]) begin
                pick_valid_o = 1'b1;
                pick_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/vx_credit_arbiter.sv
// Shared credit pool with per-requester caps; round-robin grant held stable until accepted.
module vx_credit_arbiter
    import vx_credit_arbiter_pkg::*;
#(
    parameter int NUM_REQS    = 4,
    parameter int SIZE        = 8,
    parameter int PER_REQ_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    vx_credit_arbiter_if.slave   bus
);

    localparam int IDXW  = calc_idxw(NUM_REQS);
    localparam int SIZEW = calc_sizew(SIZE);
    localparam int PCW   = calc_pcw(PER_REQ_MAX);

    state_e              state_q, state_d;
    logic [IDXW-1:0]     last_idx_q, last_idx_d;
    logic [IDXW-1:0]     hold_idx_q, hold_idx_d;
    logic [SIZEW-1:0]    pool_q, pool_d;
    logic                full_q, empty_q;
    logic [PCW-1:0]      cnt_q [NUM_REQS];
    logic [PCW-1:0]      cnt_d [NUM_REQS];

    logic [NUM_REQS-1:0] eligible;
    logic [IDXW-1:0]     pick_idx;
    logic                pick_valid;
    logic                grant_valid;
    logic [IDXW-1:0]     grant_index;
    logic                fire;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = bus.req_valid[i] && (cnt_q[i] < PCW'(PER_REQ_MAX));
        end
    end

    vx_rr_pick #(
        .NUM_REQS (NUM_REQS),
        .IDXW     (IDXW)
    ) u_rr_pick (
        .eligible_i   (eligible),
        .last_idx_i   (last_idx_q),
        .pick_idx_o   (pick_idx),
        .pick_valid_o (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        hold_idx_d  = hold_idx_q;
        last_idx_d  = last_idx_q;
        grant_valid = 1'b0;
        grant_index = pick_idx;
        case (state_q)
            IDLE: begin
                grant_valid = pick_valid && !full_q;
                if (grant_valid && !bus.grant_ready) begin
                    state_d    = LOCKED;
                    hold_idx_d = pick_idx;
                end
            end
            LOCKED: begin
                grant_valid = 1'b1;
                grant_index = hold_idx_q;
                if (bus.grant_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) grant_valid = 1'b0;
        fire = grant_valid && bus.grant_ready;
        if (fire) last_idx_d = grant_index;
    end

    // Simultaneous take and return cancel out, both for the pool and for a single requester.
    always_comb begin
        pool_d = pool_q;
        if (fire && !bus.rsp_valid)      pool_d = pool_q + 1'b1;
        else if (!fire && bus.rsp_valid) pool_d = pool_q - 1'b1;
        for (int i = 0; i < NUM_REQS; i++) begin
            cnt_d[i] = cnt_q[i];
            if ((fire && grant_index == IDXW'(i)) && !(bus.rsp_valid && bus.rsp_index == IDXW'(i)))
                cnt_d[i] = cnt_q[i] + 1'b1;
            else if (!(fire && grant_index == IDXW'(i)) && (bus.rsp_valid && bus.rsp_index == IDXW'(i)))
                cnt_d[i] = cnt_q[i] - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the small per-requester counter array is reset explicitly since stale credits would corrupt accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_idx_q <= IDXW'(NUM_REQS - 1);
            hold_idx_q <= '0;
            pool_q     <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            for (int i = 0; i < NUM_REQS; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            last_idx_q <= last_idx_d;
            hold_idx_q <= hold_idx_d;
            pool_q     <= pool_d;
            full_q     <= (pool_d == SIZEW'(SIZE));
            empty_q    <= (pool_d == '0);
            for (int i = 0; i < NUM_REQS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (fire) bus.req_ready[grant_index] = 1'b1;
    end

    assign bus.grant_valid = grant_valid;
    assign bus.grant_index = grant_index;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.size        = pool_q;

    a_hold_valid: assert property (@(posedge clk) disable iff (reset)
        (state_q == LOCKED) |-> bus.req_valid[hold_idx_q]);
    a_rsp_underflow: assert property (@(posedge clk) disable iff (reset)
        bus.rsp_valid |-> (pool_q != '0 && cnt_q[bus.rsp_index] != '0));
    a_rsp_range: assert property (@(posedge clk) disable iff (reset)
        bus.rsp_valid |-> (int'(bus.rsp_index) < NUM_REQS));

endmodule

// File: tb/tb_vx_credit_arbiter.sv
// Directed scenarios plus randomized traffic against a credit-accounting reference model.
module tb_vx_credit_arbiter;

    localparam int N   = 4;
    localparam int SZ  = 8;
    localparam int PRM = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int   m_pool;
    int   m_cnt [N];
    int   m_last;
    bit   m_locked;
    int   m_lock_idx;

    vx_credit_arbiter_if #(.NUM_REQS(N), .SIZE(SZ)) bus ();

    vx_credit_arbiter #(.NUM_REQS(N), .SIZE(SZ), .PER_REQ_MAX(PRM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected offer from the current model state and the inputs now on the bus.
    function automatic void model_offer(output bit gv, output int gi);
        gv = 1'b0;
        gi = 0;
        if (reset) return;
        if (m_locked) begin
            gv = 1'b1;
            gi = m_lock_idx;
            return;
        end
        if (m_pool == SZ) return;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (bus.req_valid[c] && m_cnt[c] < PRM) begin
                gv = 1'b1;
                gi = c;
                return;
            end
        end
    endfunction

    // Advance one clock, updating the model with what the edge should commit.
    task automatic tick();
        bit gv, fire, rsp, rst;
        int gi, ri;
        model_offer(gv, gi);
        fire = gv && bus.grant_ready;
        rsp  = bus.rsp_valid;
        ri   = int'(bus.rsp_index);
        rst  = reset;
        @(posedge clk);
        if (rst) begin
            m_pool = 0; m_last = N - 1; m_locked = 1'b0; m_lock_idx = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            if (fire) begin
                m_cnt[gi]++; m_pool++; m_last = gi; m_locked = 1'b0;
            end else if (gv) begin
                m_locked = 1'b1; m_lock_idx = gi;
            end
            if (rsp) begin
                m_cnt[ri]--; m_pool--;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0; bus.grant_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_index = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.req_valid = 4'b1111;
        bus.grant_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv_during got %0b want 0", bus.grant_valid); end
        tick();
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.size !== 4'd0) begin errors++; $display("FAIL reset_size got %0d want 0", bus.size); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", bus.full); end
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv_idle got %0b want 0", bus.grant_valid); end
        tick();
    endtask

    task automatic test_fill();
        apply_reset();
        bus.req_valid = 4'b1111;
        bus.grant_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (bus.grant_valid !== 1'b1 || int'(bus.grant_index) != k % N) begin
                errors++; $display("FAIL fill_grant k=%0d got v=%0b idx=%0d want v=1 idx=%0d", k, bus.grant_valid, bus.grant_index, k % N); end
            checks++; if (bus.req_ready !== 4'(1 << (k % N))) begin
                errors++; $display("FAIL fill_ready k=%0d got %b want %b", k, bus.req_ready, 4'(1 << (k % N))); end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (bus.full !== 1'b1 || bus.size !== 4'd8) begin
                errors++; $display("FAIL fill_full got full=%0b size=%0d want full=1 size=8", bus.full, bus.size); end
            checks++; if (bus.grant_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
                errors++; $display("FAIL fill_no_grant got v=%0b ready=%b want v=0 ready=0000", bus.grant_valid, bus.req_ready); end
            tick();
        end
    endtask

    task automatic test_full_release();
        bus.rsp_valid = 1'b1;
        bus.rsp_index = 2'd3;
        @(negedge clk);
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL bubble_gv got %0b want 0", bus.grant_valid); end
        tick();
        @(negedge clk);
        checks++; if (bus.full !== 1'b0 || bus.size !== 4'd7) begin
            errors++; $display("FAIL release_flags got full=%0b size=%0d want full=0 size=7", bus.full, bus.size); end
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_index !== 2'd0) begin
            errors++; $display("FAIL release_grant got v=%0b idx=%0d want v=1 idx=0", bus.grant_valid, bus.grant_index); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.size !== 4'd7) begin errors++; $display("FAIL fire_and_rsp_size got %0d want 7", bus.size); end
        tick();
    endtask

    task automatic test_hold();
        apply_reset();
        bus.req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.grant_valid !== 1'b1 || bus.grant_index !== 2'd2 || bus.req_ready !== 4'b0000) begin
                errors++; $display("FAIL hold_wait k=%0d got v=%0b idx=%0d ready=%b want v=1 idx=2 ready=0000", k, bus.grant_valid, bus.grant_index, bus.req_ready); end
            tick();
        end
        bus.req_valid = 4'b0101;
        @(negedge clk);
        checks++; if (bus.grant_index !== 2'd2) begin errors++; $display("FAIL hold_stable got %0d want 2", bus.grant_index); end
        tick();
        bus.grant_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant_index !== 2'd2 || bus.req_ready !== 4'b0100) begin
            errors++; $display("FAIL hold_fire got idx=%0d ready=%b want idx=2 ready=0100", bus.grant_index, bus.req_ready); end
        tick();
        @(negedge clk);
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_index !== 2'd0 || bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL hold_next got v=%0b idx=%0d ready=%b want v=1 idx=0 ready=0001", bus.grant_valid, bus.grant_index, bus.req_ready); end
        tick();
        idle_inputs();
    endtask

    task automatic test_per_req_max();
        apply_reset();
        bus.req_valid = 4'b0010;
        bus.grant_ready = 1'b1;
        for (int k = 0; k < PRM; k++) begin
            @(negedge clk);
            checks++; if (bus.grant_valid !== 1'b1 || bus.grant_index !== 2'd1) begin
                errors++; $display("FAIL cap_grant k=%0d got v=%0b idx=%0d want v=1 idx=1", k, bus.grant_valid, bus.grant_index); end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.grant_valid !== 1'b0 || bus.size !== 4'd4) begin
            errors++; $display("FAIL cap_stop got v=%0b size=%0d want v=0 size=4", bus.grant_valid, bus.size); end
        tick();
        bus.rsp_valid = 1'b1;
        bus.rsp_index = 2'd1;
        @(negedge clk);
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL cap_rsp_cycle got %0b want 0", bus.grant_valid); end
        tick();
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_index !== 2'd1 || bus.size !== 4'd3) begin
            errors++; $display("FAIL cap_resume got v=%0b idx=%0d size=%0d want v=1 idx=1 size=3", bus.grant_valid, bus.grant_index, bus.size); end
        tick();
        idle_inputs();
    endtask

    task automatic test_drain_empty();
        apply_reset();
        bus.req_valid = 4'b0001;
        bus.grant_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_index !== 2'd0) begin
            errors++; $display("FAIL drain_grant got v=%0b idx=%0d want v=1 idx=0", bus.grant_valid, bus.grant_index); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.size !== 4'd1 || bus.empty !== 1'b0) begin
            errors++; $display("FAIL drain_one got size=%0d empty=%0b want size=1 empty=0", bus.size, bus.empty); end
        tick();
        bus.rsp_valid = 1'b1;
        bus.rsp_index = 2'd0;
        tick();
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.size !== 4'd0 || bus.empty !== 1'b1) begin
            errors++; $display("FAIL drain_empty got size=%0d empty=%0b want size=0 empty=1", bus.size, bus.empty); end
        tick();
    endtask

    task automatic test_reset_locked();
        apply_reset();
        bus.req_valid = 4'b1111;
        bus.grant_ready = 1'b1;
        repeat (5) tick();
        bus.grant_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_index !== 2'd1) begin
            errors++; $display("FAIL rl_offer got v=%0b idx=%0d want v=1 idx=1", bus.grant_valid, bus.grant_index); end
        tick();
        @(negedge clk);
        checks++; if (bus.size !== 4'd5) begin errors++; $display("FAIL rl_size got %0d want 5", bus.size); end
        tick();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rl_gv_in_reset got %0b want 0", bus.grant_valid); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.grant_valid !== 1'b0 || bus.size !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            errors++; $display("FAIL rl_after got v=%0b size=%0d empty=%0b full=%0b want 0 0 1 0", bus.grant_valid, bus.size, bus.empty, bus.full); end
        tick();
        bus.req_valid = 4'b1111;
        bus.grant_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_index !== 2'd0) begin
            errors++; $display("FAIL rl_first got v=%0b idx=%0d want v=1 idx=0", bus.grant_valid, bus.grant_index); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit gv;
            int gi;
            logic [N-1:0] exp_ready;
            reset = ($urandom_range(0, 63) == 0);
            bus.req_valid = N'($urandom);
            if (m_locked) bus.req_valid[m_lock_idx] = 1'b1;
            bus.grant_ready = ($urandom_range(0, 2) != 0);
            bus.rsp_valid = 1'b0;
            bus.rsp_index = '0;
            if (m_pool > 0 && $urandom_range(0, 1) == 1) begin
                int start;
                start = $urandom_range(0, N - 1);
                for (int k = 0; k < N; k++) begin
                    if (!bus.rsp_valid && m_cnt[(start + k) % N] > 0) begin
                        bus.rsp_valid = 1'b1;
                        bus.rsp_index = 2'((start + k) % N);
                    end
                end
            end
            @(negedge clk);
            model_offer(gv, gi);
            exp_ready = (gv && bus.grant_ready) ? N'(1 << gi) : '0;
            checks++; if (bus.grant_valid !== gv || (gv && int'(bus.grant_index) != gi)) begin
                errors++; $display("FAIL rand_grant cyc=%0d got v=%0b idx=%0d want v=%0b idx=%0d", cyc, bus.grant_valid, bus.grant_index, gv, gi); end
            checks++; if (bus.req_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, bus.req_ready, exp_ready); end
            checks++; if (int'(bus.size) != m_pool || bus.full !== (m_pool == SZ) || bus.empty !== (m_pool == 0)) begin
                errors++; $display("FAIL rand_pool cyc=%0d got size=%0d full=%0b empty=%0b want size=%0d", cyc, bus.size, bus.full, bus.empty, m_pool); end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        m_pool = 0; m_last = N - 1; m_locked = 1'b0; m_lock_idx = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        reset = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_fill();
        test_full_release();
        test_hold();
        test_per_req_max();
        test_drain_empty();
        test_reset_locked();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_credit_arbiter.md
VX_CREDIT_ARBITER -- requirements
Module: vx_credit_arbiter

Interface
REQ-001 Parameter NUM_REQS, default 4, number of requesters sharing the credit pool (>=2).
REQ-002 Parameter SIZE, default 8, total credits in the shared pool (>=1).
REQ-003 Parameter PER_REQ_MAX, default 4, maximum outstanding credits per requester (1..SIZE).
REQ-004 Derived: IDXW = max(1, clog2(NUM_REQS)); SIZEW = clog2(SIZE+1); PCW = clog2(PER_REQ_MAX+1).
REQ-005 clk  input  1  clock, rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 req_valid  input  NUM_REQS  per-requester credit request.
REQ-008 req_ready  output  NUM_REQS  one-hot; bit i high when requester i's credit fires this cycle.
REQ-009 grant_valid  output  1  a credit grant is offered downstream.
REQ-010 grant_index  output  IDXW  requester being granted.
REQ-011 grant_ready  input  1  downstream accepts the grant; fire = grant_valid & grant_ready.
REQ-012 rsp_valid  input  1  one credit returned this cycle.
REQ-013 rsp_index  input  IDXW  requester whose credit is returned.
REQ-014 empty  output  1  pool count == 0, registered.
REQ-015 full  output  1  pool count == SIZE, registered.
REQ-016 size  output  SIZEW  current pool count.

Function
REQ-017 Requester i is eligible when req_valid[i] = 1 and its count < PER_REQ_MAX.
REQ-018 States: IDLE (no offer pending) and LOCKED (offer made, not yet accepted).
REQ-019 In IDLE with full = 0 and >=1 eligible requester, grant_valid asserts combinationally in the same cycle; grant_index is the first eligible requester strictly after last_idx, round-robin with wrap NUM_REQS-1 -> 0.
REQ-020 In IDLE with full = 1 or no eligible requester, grant_valid = 0.
REQ-021 grant_valid = 1 and grant_ready = 0 -> next state LOCKED; grant_index is held stable until fire, regardless of req_valid changes and of other requesters.
REQ-022 Requesters do not drop req_valid while offered; dropping it is a protocol error (assertion).
REQ-023 On fire: req_ready[grant_index] = 1; last_idx <= grant_index; state <= IDLE.
REQ-024 req_ready is 0 for every bit when no fire occurs.
REQ-025 Pool count: +1 on fire only, -1 on rsp_valid only, unchanged when both occur in the same cycle; the update is visible on the next edge.
REQ-026 Per-requester count follows the same rule, using grant_index for increment and rsp_index for decrement; when the indices differ, both counters update independently.
REQ-027 full/empty are registered and updated on the same edge as the count: full sets on an increment from SIZE-1; empty sets on a decrement from 1.
REQ-028 A grant is never offered while full = 1, even if rsp_valid is high the same cycle (one-cycle bubble).
REQ-029 Assertion: rsp_valid with pool count == 0 or count[rsp_index] == 0 is an error.
REQ-030 Assertion: rsp_index >= NUM_REQS is an error.

Reset
REQ-031 On reset: state = IDLE, pool count = 0, all per-requester counts = 0, last_idx = NUM_REQS-1, empty = 1, full = 0.
REQ-032 Reset asserted mid-operation, including in LOCKED, discards the pending offer and all outstanding credits; grant_valid = 0 during reset.
REQ-033 The first grant after reset goes to requester 0 when it is eligible.

Structure
REQ-034 The shared package holds the IDXW/SIZEW/PCW width functions and the IDLE/LOCKED state encoding.
REQ-035 The round-robin selection lives in one sub-module, vx_rr_pick (eligible mask + last_idx -> index + valid), combinational only.
REQ-036 All state (state register, last_idx, pool count, flags, per-requester counters) resides in vx_credit_arbiter.

Verification
REQ-037 Reset; req_valid = 4'b1111, grant_ready = 1 continuously -> grants 0,1,2,3,0,1,2,3, then full = 1 and size = 8, and no grant while full.
REQ-038 req_valid = 4'b0100, grant_ready = 0 for 3 cycles, then req_valid = 4'b0101 -> grant_index stays 2 throughout; fires on grant_ready; next grant goes to 0.
REQ-039 PER_REQ_MAX = 4, only req 1 valid, grant_ready = 1 -> 4 grants, then grant_valid = 0 with size = 4; one rsp for index 1 -> grant resumes the next cycle.
REQ-040 size = 8 (full): rsp_valid for index 3 -> next cycle full = 0, size = 7, grant offered; same-cycle fire and rsp -> size unchanged.
REQ-041 size = 1: rsp_valid -> empty = 1, size = 0; an extra rsp triggers the assertion.
REQ-042 Reset in LOCKED with size = 5 -> next cycle grant_valid = 0, size = 0, empty = 1, full = 0.
